// File: rtl/toom8_pkg.sv
// Shared constants and state encoding for the Toom-8 recomposition stage.
package toom8_pkg;
  localparam int LIMB_W = 128;
  localparam int N_COEF = 15;
  localparam int N_LIMB = 16;
  localparam int PROD_W = 2048;

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    DONE
  } state_t;
endpackage

// File: rtl/toom8_window_step.sv
// One carry-propagation step: adds a coefficient into the signed window and
// splits the sum into the finished low limb and the shifted-down new window.
module toom8_window_step
  import toom8_pkg::*;
#(
  parameter int ACC_W = 274
) (
  input  logic signed [ACC_W-1:0]  w,
  input  logic signed [ACC_W-1:0]  c,
  output logic        [LIMB_W-1:0] limb,
  output logic signed [ACC_W-1:0]  w_next
);
  logic signed [ACC_W-1:0] s;

  assign s      = w + c;
  assign limb   = s[LIMB_W-1:0];
  assign w_next = s >>> LIMB_W;
endmodule

// File: rtl/toom8_recompose.sv
// Evaluates the 15-coefficient product polynomial at 2^128 by streaming the
// coefficients through a signed carry window, then presents the 2048-bit product.
module toom8_recompose
  import toom8_pkg::*;
#(
  parameter int COEF_W = 272
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_last,
  output logic              prod_valid,
  input  logic              prod_ready,
  output logic [PROD_W-1:0] product,
  output logic              ovf_err,
  output logic              frame_err
);
  localparam int ACC_W = COEF_W + 2;

  state_t                  state_q, state_d;
  logic                    armed_q;
  logic signed [ACC_W-1:0] w_q;
  logic signed [ACC_W-1:0] w_step;
  logic signed [ACC_W-1:0] c_ext;
  logic signed [ACC_W-1:0] w_resid;
  logic [3:0]              idx_q;
  logic [LIMB_W-1:0]       limb_q [N_LIMB];
  logic [LIMB_W-1:0]       step_limb;
  logic                    ovf_q, frame_q;
  logic                    coef_fire, prod_fire, last_idx;

  // armed_q keeps coef_ready low until the first edge after reset release.
  assign coef_ready = (state_q == ACCUM) && armed_q;
  assign prod_valid = (state_q == DONE);
  assign coef_fire  = coef_valid && coef_ready;
  assign prod_fire  = prod_valid && prod_ready;
  assign last_idx   = (idx_q == 4'(N_COEF - 1));
  assign c_ext      = {{(ACC_W - COEF_W){coef_data[COEF_W-1]}}, coef_data};
  assign w_resid    = w_q >>> LIMB_W;
  assign ovf_err    = ovf_q;
  assign frame_err  = frame_q;

  toom8_window_step #(
    .ACC_W (ACC_W)
  ) u_step (
    .w      (w_q),
    .c      (c_ext),
    .limb   (step_limb),
    .w_next (w_step)
  );

  always_comb begin
    for (int i = 0; i < N_LIMB; i++) begin
      product[i*LIMB_W +: LIMB_W] = limb_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (coef_fire && last_idx) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (prod_fire) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Framing errors are only flagged; the frame length is always 15 coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      armed_q <= 1'b0;
      w_q     <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      frame_q <= 1'b0;
      for (int i = 0; i < N_LIMB; i++) begin
        limb_q[i] <= '0;
      end
    end else begin
      armed_q <= 1'b1;
      state_q <= state_d;
      case (state_q)
        ACCUM: begin
          if (coef_fire) begin
            limb_q[idx_q] <= step_limb;
            w_q           <= w_step;
            idx_q         <= idx_q + 4'd1;
            if (coef_last != last_idx) frame_q <= 1'b1;
          end
        end
        FLUSH: begin
          limb_q[N_LIMB-1] <= w_q[LIMB_W-1:0];
          ovf_q            <= (w_resid != '0);
        end
        DONE: begin
          if (prod_fire) begin
            w_q     <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            frame_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_toom8_recompose.sv
// Scoreboard bench for toom8_recompose: directed frames push expected products,
// a negedge monitor pops and compares whenever a product is handed off.
module tb_toom8_recompose;
  localparam int COEF_W = 272;
  localparam int PROD_W = 2048;

  typedef logic [COEF_W-1:0] coef_t;
  typedef struct {
    logic [PROD_W-1:0] product;
    logic              ovf;
    logic              frame;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic              coef_last;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] product;
  logic              ovf_err;
  logic              frame_err;

  int    checks   = 0;
  int    failures = 0;
  exp_t  exp_q [$];
  coef_t cur_c [15];
  logic  cur_last [15];

  toom8_recompose #(.COEF_W(COEF_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_last  (coef_last),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .ovf_err    (ovf_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Compare wide values; on a miss report only the first differing limb.
  task automatic checkOutput(input string name, input logic [PROD_W-1:0] act,
                             input logic [PROD_W-1:0] req);
    int first;
    checks++;
    if (act !== req) begin
      failures++;
      first = 0;
      for (int i = 15; i >= 0; i--) begin
        if (act[i*128 +: 128] !== req[i*128 +: 128]) first = i;
      end
      $display("[TB] FAIL %s limb%0d actual=%h required=%h", name, first,
               act[first*128 +: 128], req[first*128 +: 128]);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic req);
    checkOutput(name, PROD_W'(act), PROD_W'(req));
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 15; i++) begin
      cur_c[i]    = '0;
      cur_last[i] = (i == 14);
    end
  endtask

  // Big-integer reference: sum c_i * 2^(128 i) evaluated directly.
  function automatic logic [PROD_W-1:0] model_product(output logic ovf);
    logic signed [2175:0] acc;
    logic signed [2175:0] t;
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      t   = {{(2176-COEF_W){cur_c[i][COEF_W-1]}}, cur_c[i]};
      acc = acc + (t <<< (128 * i));
    end
    ovf = ((acc >>> PROD_W) != '0);
    return acc[PROD_W-1:0];
  endfunction

  task automatic feed_coef(input int i);
    int n;
    coef_valid = 1'b1;
    coef_data  = cur_c[i];
    coef_last  = cur_last[i];
    n = 0;
    while (!coef_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!coef_ready) checkFlag("coef_ready_timeout", coef_ready, 1'b1);
    @(posedge clk); #1;
    coef_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [PROD_W-1:0] e_prod,
                               input logic e_ovf, input logic e_frame,
                               input bit bubbles, input int hold);
    exp_t e;
    int   n;
    e.product = e_prod;
    e.ovf     = e_ovf;
    e.frame   = e_frame;
    exp_q.push_back(e);
    $display("[TB] frame %s", name);
    prod_ready = (hold == 0);
    for (int i = 0; i < 15; i++) begin
      if (bubbles && (i % 3 == 1)) begin
        coef_valid = 1'b0;
        @(posedge clk); #1;
      end
      feed_coef(i);
    end
    checkFlag("latency_flush", prod_valid, 1'b0);
    @(posedge clk); #1;
    checkFlag("latency_done", prod_valid, 1'b1);
    for (int k = 0; k < hold; k++) begin
      coef_valid = 1'b1;
      coef_data  = '1;
      checkFlag("stall_coef_ready", coef_ready, 1'b0);
      checkFlag("stall_prod_valid", prod_valid, 1'b1);
      checkOutput("stall_product", product, e_prod);
      checkFlag("stall_ovf", ovf_err, e_ovf);
      checkFlag("stall_frame", frame_err, e_frame);
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    prod_ready = 1'b1;
    n = 0;
    while (prod_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (prod_valid) checkFlag("done_exit_timeout", prod_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    checkFlag({name, "_coef_ready"}, coef_ready, 1'b0);
    checkFlag({name, "_prod_valid"}, prod_valid, 1'b0);
    checkOutput({name, "_product"}, product, '0);
    checkFlag({name, "_ovf"}, ovf_err, 1'b0);
    checkFlag({name, "_frame"}, frame_err, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkFlag("ready_before_edge", coef_ready, 1'b0);
    @(posedge clk); #1;
    checkFlag("ready_after_edge", coef_ready, 1'b1);
  endtask

  // Monitor: pops one expectation per product handoff.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && prod_valid && prod_ready) begin
        if (exp_q.size() == 0) begin
          checkFlag("unexpected_product", prod_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("product", product, e.product);
          checkFlag("ovf_err", ovf_err, e.ovf);
          checkFlag("frame_err", frame_err, e.frame);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [PROD_W-1:0] e;
    logic              m_ovf;
    rst_n      = 1'b0;
    coef_valid = 1'b0;
    coef_data  = '0;
    coef_last  = 1'b0;
    prod_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    clear_frame();
    applyStimulus("zeros", '0, 1'b0, 1'b0, 1'b0, 0);

    clear_frame();
    cur_c[0] = coef_t'(1);
    applyStimulus("one", PROD_W'(1), 1'b0, 1'b0, 1'b0, 0);

    clear_frame();
    for (int i = 0; i < 15; i++) cur_c[i][127:0] = '1;
    e = model_product(m_ovf);
    applyStimulus("carry_chain", e, m_ovf, 1'b0, 1'b1, 0);

    clear_frame();
    cur_c[0][128] = 1'b1;
    cur_c[1] = '1;
    applyStimulus("borrow", '0, 1'b0, 1'b0, 1'b0, 0);

    clear_frame();
    cur_c[14][256] = 1'b1;
    applyStimulus("ovf_high", '0, 1'b1, 1'b0, 1'b0, 0);

    clear_frame();
    cur_c[0] = '1;
    applyStimulus("ovf_negative_stall", '1, 1'b1, 1'b0, 1'b0, 5);

    clear_frame();
    cur_c[3]    = coef_t'(5);
    cur_last[7] = 1'b1;
    applyStimulus("early_last", PROD_W'(5) << 384, 1'b0, 1'b1, 1'b1, 0);

    clear_frame();
    cur_c[2]     = coef_t'(7);
    cur_last[14] = 1'b0;
    applyStimulus("missing_last", PROD_W'(7) << 256, 1'b0, 1'b1, 1'b0, 0);

    clear_frame();
    cur_c[1] = coef_t'(3);
    applyStimulus("flags_cleared", PROD_W'(3) << 128, 1'b0, 1'b0, 1'b0, 0);

    clear_frame();
    for (int i = 0; i < 6; i++) cur_c[i] = coef_t'(i + 9);
    cur_last[2] = 1'b1;
    for (int i = 0; i < 6; i++) feed_coef(i);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    release_reset();

    clear_frame();
    cur_c[0] = -coef_t'(5);
    cur_c[1] = coef_t'(1);
    applyStimulus("after_reset", (PROD_W'(1) << 128) - PROD_W'(5), 1'b0, 1'b0, 1'b1, 0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", PROD_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
